ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// - PS/2 host-to-device transmitter: the write direction of the keyboard link, opposite to the keyboard receiver.
// - Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable) and checks the device ACK.
// - Runs on clk100 next to the keyboard receiver; drives PS/2 clock and data as open-drain pull-low enables.
// - busy marks frames the receiver must ignore.
// PARAMETERS
// - INHIBIT_CYCLES  12000    cycles host holds PS/2 clock low before start (120 us at 100 MHz)
// - TIMEOUT_CYCLES  1500000  max cycles from clock release to ACK (15 ms); exceeding aborts
// - FILTER_LEN      4        cycles a synchronized line must be stable before its filtered value changes
// PORTS
// - clk             in   1  system clock (clk100); sole clock
// - reset           in   1  synchronous, active-high
// - tx_data         in   8  command byte, sampled at accept
// - tx_valid        in   1  request to send tx_data
// - tx_ready        out  1  high only in IDLE; accept = tx_valid & tx_ready
// - ps2_clk_in      in   1  raw PS/2 clock pin level (async)
// - ps2_data_in     in   1  raw PS/2 data pin level (async)
// - ps2_clk_low     out  1  1 = pull PS/2 clock low, 0 = release (hi-Z)
// - ps2_data_low    out  1  1 = pull PS/2 data low, 0 = release
// - busy            out  1  high in every state except IDLE
// - done            out  1  1-cycle pulse at frame end; ack_ok valid in the same cycle
// - ack_ok          out  1  1 = device ACKed (data low at 11th falling edge), held until next accept
// - err             out  1  1-cycle pulse on timeout; done is not pulsed
// BEHAVIOUR
// - Reset: all outputs 0 except tx_ready=1; state IDLE, both lines released.
// - Reset takes effect the cycle after assertion, even mid-frame.
// - Outputs are registered: each line-drive change appears one cycle after the state change.
// - Input path: 2-FF synchronizer, then a FILTER_LEN stability filter per line.
// - fall_clk = filtered clock 1->0. Edge latency after the pin transition: 2+FILTER_LEN cycles.
// - Accept: latch byte; parity = ~^tx_data (odd parity); bit index idx=0; go to INHIBIT.
// - INHIBIT: clk_low=1, data_low=0. Count INHIBIT_CYCLES, then go to START.
// - START: data_low=1 (start bit), then clk_low=0 the next cycle. Timeout counter clears; go to SEND.
// - SEND: on each fall_clk, drive a bit with data_low = ~bit.
// - SEND bit order: idx 0..7 = data LSB first, idx 8 = parity, idx 9 = stop (release, data_low=0).
// - SEND: after idx 9 is driven, go to WAIT_ACK.
// - WAIT_ACK: on the next fall_clk, sample filtered data; ack_ok = ~data. Go to WAIT_IDLE.
// - WAIT_IDLE: when filtered clock and data are both 1, pulse done and return to IDLE.
// - Timeout counter runs from START through WAIT_IDLE.
// - On reaching TIMEOUT_CYCLES: release both lines, pulse err, ack_ok=0, go to IDLE. This covers a device that never clocks.
// - tx_valid while busy is ignored; no queueing. done and accept may not coincide: tx_ready rises the cycle after done.
// - fall_clk during INHIBIT or START is ignored.
// - Counter widths: $clog2(X+1) of the respective parameter; no wrap, saturate at the limit.
// STRUCTURE
// - ps2_pkg: state enum {IDLE, INHIBIT, START, SEND, WAIT_ACK, WAIT_IDLE}; STOP_IDX=9, PARITY_IDX=8.
//   The keyboard receiver shares ps2_pkg for frame constants.
// - Sub-module ps2_line_filter (one per line): synchronizer + stability filter + fall pulse.
//   The keyboard receiver is to reuse it.
// - Top: FSM, 4-bit idx, inhibit/timeout counters, 9-bit shift register {parity, data}.
// TESTING
// - Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=20000, FILTER_LEN=4.
// - Bench device model: PS/2 clock period 400 cycles; it samples data on rising edges.
// - Send 0xED -> clk low 20 cycles; model sees start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
//   With ACK low -> done=1, ack_ok=1.
// - Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0. Model withholds ACK -> done=1, ack_ok=0.
// - Send 0x00 -> parity 1. Model never clocks -> err pulse at cycle 20000 after START.
//   Lines released; tx_ready=1 next cycle.
// - tx_valid held high with 0xAA during a frame -> second byte sent only after done.
//   No change to the in-flight bits.
// - Assert reset at idx 5 -> both lines released, busy=0, tx_ready=1 within 1 cycle.
// - 2-cycle glitch on clock pin during SEND -> no fall_clk; bit sequence unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
//
// Contents:
//   - FSM state codes for the host-to-device transmitter
//   - frame bit indices (data 0..7, parity, stop)
//   - odd_parity(): parity bit that makes the 9-bit {parity, data} odd
// -----------------------------------------------------------------------------
package ps2_pkg;

    // Transmitter FSM state codes.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_ACK  = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    // Bit positions inside a frame after the start bit.
    localparam logic [3:0] PARITY_IDX = 4'd8;
    localparam logic [3:0] STOP_IDX   = 4'd9;

    // PS/2 uses odd parity: the parity bit is 1 when the data has an even
    // number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// -----------------------------------------------------------------------------
// ps2_line_filter
// Conditions one raw PS/2 pin (clock or data) for use in the clk100 domain.
//
// A 2-FF synchronizer is followed by a stability filter: the filtered level
// only follows the synchronized value once it has differed from the current
// filtered level for FILTER_LEN consecutive cycles. Shorter glitches are
// dropped. A one-cycle fall pulse accompanies every filtered 1->0 change.
// Latency from a pin transition to the filtered change is 2+FILTER_LEN cycles.
//
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high; line idles high after reset
//   line_in  in  raw pin level (asynchronous)
//   level    out filtered line level
//   fall     out 1-cycle pulse when level goes 1->0
// -----------------------------------------------------------------------------
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            fall  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
            fall  <= 1'b0;
            if (sync2 == level) begin
                // Any return to the filtered level restarts the stability count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the FILTER_LEN-th consecutive differing sample.
                level <= sync2;
                fall  <= ~sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard and
// reports whether the device acknowledged it.
//
// Frame sequence:
//   INHIBIT   hold PS/2 clock low for INHIBIT_CYCLES
//   START     pull data low (start bit), then release clock the next cycle
//   SEND      on each device falling clock edge put out the next bit:
//             idx 0..7 data LSB first, idx 8 parity, idx 9 stop (released)
//   WAIT_ACK  on the next falling edge sample data: low means ACK
//   WAIT_IDLE wait for both lines high, then pulse done
// A timeout counter runs from START through WAIT_IDLE; reaching
// TIMEOUT_CYCLES releases the lines, pulses err and returns to IDLE.
//
// Handshake: a request is taken in the cycle where tx_valid and tx_ready are
// both high (tx_data is latched then). tx_ready is high only in IDLE and rises
// the cycle after done/err, so completion and a new accept never coincide.
// tx_valid while busy is ignored; nothing is queued.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   tx_data/valid  command byte and request; tx_ready accept qualifier
//   ps2_clk_in     raw PS/2 clock pin level
//   ps2_data_in    raw PS/2 data pin level
//   ps2_clk_low    1 = pull PS/2 clock low (open-drain enable)
//   ps2_data_low   1 = pull PS/2 data low (open-drain enable)
//   busy           high in every state except IDLE
//   done           1-cycle pulse at frame end, ack_ok valid alongside
//   ack_ok         device ACK result, held until the next accept
//   err            1-cycle pulse on timeout (done not pulsed)
// -----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

    logic [2:0]       state;
    logic [3:0]       idx;
    logic [8:0]       shreg;       // {parity, data}, shifted out LSB first
    logic [INH_W-1:0] inh_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             start_phase; // 0: drive start bit, 1: release clock

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    logic accept;
    logic timing;

    // -------------------------------------------------------------------------
    // Input conditioning, one filter per line
    // -------------------------------------------------------------------------
    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_data_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    assign accept = tx_valid & tx_ready;
    assign busy   = (state != IDLE);

    // The timeout window opens once the clock is released (second START
    // cycle) and stays open until the frame completes.
    assign timing = (state == SEND) || (state == WAIT_ACK) ||
                    (state == WAIT_IDLE) || ((state == START) && start_phase);

    // -------------------------------------------------------------------------
    // FSM, counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            shreg        <= '0;
            inh_cnt      <= '0;
            to_cnt       <= '0;
            start_phase  <= 1'b0;
            ps2_clk_low  <= 1'b0;
            ps2_data_low <= 1'b0;
            tx_ready     <= 1'b1;
            done         <= 1'b0;
            ack_ok       <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    tx_ready     <= 1'b1;
                    if (accept) begin
                        shreg    <= {odd_parity(tx_data), tx_data};
                        idx      <= '0;
                        inh_cnt  <= '0;
                        ack_ok   <= 1'b0;
                        tx_ready <= 1'b0;
                        state    <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    ps2_clk_low  <= 1'b1;
                    ps2_data_low <= 1'b0;
                    if (inh_cnt == INH_LAST) begin
                        start_phase <= 1'b0;
                        state       <= START;
                    end else begin
                        inh_cnt <= inh_cnt + INH_ONE;
                    end
                end

                START: begin
                    // Data goes low while the clock is still held, so the
                    // device sees a request-to-send when the clock releases.
                    if (!start_phase) begin
                        ps2_data_low <= 1'b1;
                        to_cnt       <= '0;
                        start_phase  <= 1'b1;
                    end else begin
                        ps2_clk_low <= 1'b0;
                        state       <= SEND;
                    end
                end

                SEND: begin
                    if (clk_fall) begin
                        if (idx <= PARITY_IDX) begin
                            ps2_data_low <= ~shreg[0];
                            shreg        <= {1'b0, shreg[8:1]};
                            idx          <= idx + 4'd1;
                        end else begin
                            // idx == STOP_IDX: stop bit is a released line.
                            ps2_data_low <= 1'b0;
                            state        <= WAIT_ACK;
                        end
                    end
                end

                WAIT_ACK: begin
                    if (clk_fall) begin
                        ack_ok <= ~data_level;
                        state  <= WAIT_IDLE;
                    end
                end

                WAIT_IDLE: begin
                    if (clk_level && data_level) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    state        <= IDLE;
                end
            endcase

            // Timeout overrides whatever the state logic decided this cycle.
            if (timing) begin
                if (to_cnt == TO_LAST) begin
                    ps2_clk_low  <= 1'b0;
                    ps2_data_low <= 1'b0;
                    ack_ok       <= 1'b0;
                    err          <= 1'b1;
                    done         <= 1'b0;
                    state        <= IDLE;
                end else begin
                    to_cnt <= to_cnt + TO_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 20000;
  localparam int FL  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       err;

  // open-drain bus: any pull-low wins, otherwise pulled up
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch_low   = 1'b0;
  logic pin_clk;
  logic pin_data;
  assign pin_clk  = ~(ps2_clk_low | dev_clk_low | glitch_low);
  assign pin_data = ~(ps2_data_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .ps2_clk_in   (pin_clk),
    .ps2_data_in  (pin_data),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low),
    .busy         (busy),
    .done         (done),
    .ack_ok       (ack_ok),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time budget exhausted before summary");
    $fatal(1, "time budget exhausted");
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic exp_q[$];
  logic got_q[$];
  logic got_start;

  logic fe_done, fe_err, fe_ack, fe_ready;

  // length of the most recent host clock-low drive
  int clk_low_run      = 0;
  int last_clk_low_run = 0;
  always @(negedge clk) begin
    if (ps2_clk_low === 1'b1) clk_low_run++;
    else if (clk_low_run != 0) begin
      last_clk_low_run = clk_low_run;
      clk_low_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: bits the device should sample after the start bit
  task automatic build_expected(input logic [7:0] b);
    int ones;
    int bv;
    exp_q.delete();
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      bv = (int'(b) >> i) & 1;
      ones += bv;
      exp_q.push_back(bv == 1);
    end
    exp_q.push_back((ones % 2) == 0);
    exp_q.push_back(1'b1);
  endtask

  // behavioural keyboard: 400-cycle clock, samples data on rising edges,
  // optional ACK, optional 2-cycle clock glitch, optional reset mid-frame
  task automatic device_frame(input bit give_ack, input bit glitch, input int reset_after_fall);
    int w;
    got_q.delete();
    w = 0;
    while (!(pin_clk === 1'b1 && pin_data === 1'b0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("rts_seen", (w < 500), 1);
    if (w >= 500) return;
    got_start = pin_data;
    wait_cyc(50);
    for (int i = 0; i < 11; i++) begin
      wait_cyc(100);
      if (i == 10 && give_ack) dev_data_low = 1'b1;
      if (glitch && i == 4) begin
        glitch_low = 1'b1;
        wait_cyc(2);
        glitch_low = 1'b0;
        wait_cyc(98);
      end else begin
        wait_cyc(100);
      end
      dev_clk_low = 1'b1;
      if (i == reset_after_fall) begin
        wait_cyc(20);
        check("pre_reset_data_low", ps2_data_low, 1);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        wait_cyc(1);
        check("rst_mid_clk_low", ps2_clk_low, 0);
        check("rst_mid_data_low", ps2_data_low, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tx_ready", tx_ready, 1);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        return;
      end
      wait_cyc(200);
      dev_clk_low = 1'b0;
      if (i < 10) got_q.push_back(pin_data);
    end
    wait_cyc(100);
    dev_data_low = 1'b0;
  endtask

  task automatic frame_end(input int budget);
    int c;
    c = 0;
    while (done !== 1'b1 && err !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    fe_done  = done;
    fe_err   = err;
    fe_ack   = ack_ok;
    fe_ready = tx_ready;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit give_ack, input bit glitch,
                           input bit do_send, input bit hold_next, input logic [7:0] next_b);
    if (do_send) begin
      tx_data  = b;
      tx_valid = 1'b1;
      wait_cyc(1);
      check("accept_busy", busy, 1);
      check("accept_ready_low", tx_ready, 0);
    end
    if (hold_next) tx_data = next_b;
    else tx_valid = 1'b0;
    build_expected(b);
    fork
      device_frame(give_ack, glitch, -1);
      frame_end(8000);
    join
    check("done_pulse", fe_done, 1);
    check("no_err", fe_err, 0);
    check("ack_ok", fe_ack, give_ack);
    check("ready_low_at_done", fe_ready, 0);
    check("start_bit", got_start, 0);
    check_range("inhibit_len", last_clk_low_run, INH, INH + 3);
    check("bit_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%02h_bit%0d", b, i), got_q[i], exp_q[i]);
    wait_cyc(1);
    check("done_one_cycle", done, 0);
    check("ready_after_done", tx_ready, 1);
    if (hold_next) begin
      wait_cyc(1);
      check("held_accept", busy, 1);
      tx_valid = 1'b0;
    end
  endtask

  initial begin
    int c;
    logic [7:0] b;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_ok", ack_ok, 0);
    check("rst_err", err, 0);
    check("rst_clk_low", ps2_clk_low, 0);
    check("rst_data_low", ps2_data_low, 0);

    // 0xED with ACK while tx_valid stays high presenting 0xAA
    run_frame(8'hED, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    // 0xAA was accepted right after done
    run_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    // 0xF4, no ACK, with a clock glitch mid-frame
    run_frame(8'hF4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    // random bytes, random ACK and glitch
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 255));
      run_frame(b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 8'h00);
    end

    // reset while idx 5 is on the line (bit 5 forced to 0 so data is pulled)
    b = 8'($urandom_range(0, 255)) & 8'hDF;
    tx_data  = b;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
    device_frame(1'b1, 1'b0, 5);
    wait_cyc(500);
    run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);

    // 0x00, device never clocks -> timeout
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_cyc(1);
    tx_valid = 1'b0;
    c = 0;
    while (ps2_clk_low !== 1'b1 && c < 100) begin wait_cyc(1); c++; end
    while (ps2_clk_low !== 1'b0 && c < 200) begin wait_cyc(1); c++; end
    check("to_clk_released", (c < 200), 1);
    check("to_start_bit_held", ps2_data_low, 1);
    c = 0;
    while (err !== 1'b1 && c < TO + 5000) begin wait_cyc(1); c++; end
    check_range("to_err_latency", c, TO - 2, TO + 2);
    check("to_no_done", done, 0);
    check("to_clk_rel", ps2_clk_low, 0);
    check("to_data_rel", ps2_data_low, 0);
    check("to_ack_ok", ack_ok, 0);
    wait_cyc(1);
    check("to_err_one_cycle", err, 0);
    check("to_ready_next", tx_ready, 1);
    check("to_not_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
